// File: rtl/dma_pkg.sv
// Shared types for the 8237A-compatible DMA controller:
// cycle states, channel modes and transfer types.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_SI,
      ST_S0,
      ST_S1,
      ST_S2,
      ST_S3,
      ST_S4
   } dma_state_e;

   typedef enum logic [1:0] {
      MODE_DEMAND = 2'b00,
      MODE_SINGLE = 2'b01,
      MODE_BLOCK  = 2'b10,
      MODE_RSVD   = 2'b11
   } dma_mode_e;

   typedef enum logic [1:0] {
      XF_VERIFY  = 2'b00,
      XF_WRITE   = 2'b01,
      XF_READ    = 2'b10,
      XF_ILLEGAL = 2'b11
   } dma_xfer_e;

endpackage

// File: rtl/dma_timing_control.sv
// 8237A transfer-cycle sequencer: hold handshake, SI..S4
// bus cycle, strobe decode and TC/EOP termination.
module dma_timing_control
   import dma_pkg::*;
(
   input  logic       Clock,
   input  logic       ResetN,
   input  logic       ValidReqID,
   input  logic [1:0] ReqID,
   input  logic       Hlda,
   input  logic       Ready,
   input  logic       DreqActive,
   input  logic [1:0] Mode,
   input  logic [1:0] XferType,
   input  logic       TcIn,
   input  logic       AddrCarry,
   input  logic       EopInN,
   output logic       Hrq,
   output logic       Aen,
   output logic       Adstb,
   output logic       MemRdN,
   output logic       MemWrN,
   output logic       IorN,
   output logic       IowN,
   output logic       EopOutN,
   output logic       UpdateAddr,
   output logic [1:0] Channel,
   output logic       TcDone
);

   dma_state_e state, state_nxt;
   dma_mode_e  mode;
   dma_xfer_e  xfer;
   logic       eop_seen;
   logic       end_c;
   logic       rd_act, wr_act;
   logic [1:0] channel_q;

   assign mode    = dma_mode_e'(Mode);
   assign xfer    = dma_xfer_e'(XferType);
   assign Channel = channel_q;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state     <= ST_SI;
         channel_q <= 2'b00;
         eop_seen  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_SI && ValidReqID)
            channel_q <= ReqID;
         // external EOP seen mid-word ends the service at S4
         if ((state == ST_S2 || state == ST_S3) &&
             !EopInN && Hlda)
            eop_seen <= 1'b1;
         else if (state == ST_S4 || state == ST_SI)
            eop_seen <= 1'b0;
      end
   end

   assign end_c = TcIn | ~EopInN | eop_seen;

   always_comb begin
      state_nxt  = state;
      UpdateAddr = 1'b0;
      TcDone     = 1'b0;
      EopOutN    = 1'b1;
      unique case (state)
         ST_SI: if (ValidReqID) state_nxt = ST_S0;
         ST_S0: if (Hlda) state_nxt = ST_S1;
         ST_S1: state_nxt = Hlda ? ST_S2 : ST_SI;
         ST_S2: state_nxt = Hlda ? ST_S3 : ST_SI;
         ST_S3: begin
            if (!Hlda)
               state_nxt = ST_SI;
            else if (Ready)
               state_nxt = ST_S4;
         end
         ST_S4: begin
            if (!Hlda) begin
               state_nxt = ST_SI;
            end else begin
               UpdateAddr = 1'b1;
               if (end_c) begin
                  TcDone    = 1'b1;
                  EopOutN   = ~TcIn;
                  state_nxt = ST_SI;
               end else begin
                  unique case (mode)
                     MODE_BLOCK:
                        state_nxt = AddrCarry ? ST_S1 : ST_S2;
                     MODE_DEMAND:
                        state_nxt = !DreqActive ? ST_SI :
                                    AddrCarry   ? ST_S1 : ST_S2;
                     MODE_SINGLE,
                     MODE_RSVD:
                        state_nxt = ST_SI;
                  endcase
               end
            end
         end
         default: state_nxt = ST_SI;
      endcase
   end

   assign rd_act = (state == ST_S2) || (state == ST_S3);
   assign wr_act = (state == ST_S3);

   always_comb begin
      Hrq    = (state != ST_SI);
      Aen    = (state == ST_S1) || (state == ST_S2) ||
               (state == ST_S3) || (state == ST_S4);
      Adstb  = (state == ST_S1);
      IorN   = !(rd_act && xfer == XF_WRITE);
      MemRdN = !(rd_act && xfer == XF_READ);
      MemWrN = !(wr_act && xfer == XF_WRITE);
      IowN   = !(wr_act && xfer == XF_READ);
   end

endmodule

// File: doc/dma_timing_control.md
# dma_timing_control

Transfer-cycle sequencer of the 8237A-compatible DMA controller, directly downstream of the channel priority encoder. Takes the arbitrated request (ValidReqID/ReqID), raises HRQ, waits for HLDA, then runs the classic SI/S0/S1/S2/S3/S4 bus cycle, driving address-enable, address-strobe and the four active-low read/write strobes. Pulses the address/count datapath once per transferred word and terminates on terminal count or external EOP.

## Interface
Parameters:
- None; all widths fixed by the 8237A bus.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- ResetN  in  1  reset; one clock; reset is asynchronous and active-low.
- ValidReqID  in  1  arbitrated request pending (from priority encoder).
- ReqID  in  2  winning channel (from priority encoder).
- Hlda  in  1  hold acknowledge from CPU.
- Ready  in  1  slow-device ready; low inserts wait states in S3.
- DreqActive  in  1  sensed, unmasked DREQ of the current channel (demand mode).
- Mode  in  2  current channel mode: 00 demand, 01 single, 10 block, 11 reserved (treated as single).
- XferType  in  2  00 verify, 01 write (I/O→mem), 10 read (mem→I/O), 11 illegal (treated as verify).
- TcIn  in  1  current word count at terminal value (from datapath).
- AddrCarry  in  1  next address changes A15:A8.
- EopInN  in  1  external end-of-process, active low.
- Hrq  out  1  hold request to CPU.
- Aen  out  1  address enable.
- Adstb  out  1  upper-address strobe.
- MemRdN, MemWrN, IorN, IowN  out  1 each  bus strobes, active low.
- EopOutN  out  1  terminal-count indication, active low.
- UpdateAddr  out  1  one-cycle pulse: increment/decrement address, decrement count.
- Channel  out  2  channel latched for the current service.
- TcDone  out  1  one-cycle pulse: current channel reached TC/EOP (sets status bit).

## Operation
- States: SI, S0, S1, S2, S3, S4.
- SI: idle. ValidReqID=1 → latch Channel←ReqID, go S0.
- S0: Hrq=1. Hlda=1 → S1. Stay otherwise.
- S1: Aen=1, Adstb=1 → S2.
- S2: Aen=1. Read strobe asserted: IorN=0 (write type) or MemRdN=0 (read type); none for verify → S3.
- S3: read strobe held; write strobe asserted: MemWrN=0 (write) or IowN=0 (read). Ready=0 → stay S3 (wait state). Ready=1 → S4.
- S4: all strobes high, Aen=1, UpdateAddr=1. End condition E = TcIn or EopInN==0. If E: EopOutN=0 (TcIn only), TcDone=1, → SI.
- S4 without E: single → SI; block → S1 if AddrCarry else S2; demand → (DreqActive ? (AddrCarry ? S1 : S2) : SI).
- Hlda falling in any of S1–S4 → SI immediately, strobes released, no UpdateAddr.
- EopInN low sampled in S2/S3 is remembered and applied in the following S4.
- Outputs are Moore decodes of registered state except EopOutN/TcDone/UpdateAddr (S4 decode with inputs).

## Timing
- Reset (ResetN low, async): state SI; Hrq=0, Aen=0, Adstb=0, all strobes=1, EopOutN=1, UpdateAddr=0, TcDone=0, Channel=0.
- ValidReqID sampled at edge N in SI → Hrq=1 from N+1.
- Hlda sampled at edge M in S0 → S1 during M+1; first word: S1,S2,S3,S4 = 4 cycles after S0 with Ready=1; each wait state adds 1.
- Block continuation without carry: 3 cycles/word (S2,S3,S4).
- Hrq drops the cycle after leaving S4 to SI.
- ValidReqID ignored outside SI; Channel stable from S0 to return to SI.

## Structure
- Shared dma_pkg: state enum (SI..S4), mode enum, transfer-type enum, used also by mode register and datapath.
- Single module; strobe decode kept as an always_comb inside, no sub-module.

## Test plan
- Single write, ReqID=2, Hlda after 2 cycles, Ready=1 → Channel=2, IorN low S2–S3, MemWrN low S3, one UpdateAddr, Hrq low after S4.
- Block read, TcIn rises on 3rd word → 3 UpdateAddr pulses, EopOutN=0 and TcDone=1 in 3rd S4, S1 visited only on first word and when AddrCarry=1.
- Ready held low 2 cycles in S3 → S3 lasts 3 cycles, strobes held, single UpdateAddr.
- Demand mode, DreqActive drops after 2nd word → returns SI after 2nd S4, TcDone=0.
- EopInN pulsed low in S2 of block transfer → terminates in that S4, TcDone=1, EopOutN stays 1.
- ResetN low during S3 → strobes high, Hrq=0 immediately; Hlda drop in S2 → SI, no UpdateAddr.
